// File: rtl/filter_frame_ctrl.sv
`timescale 1ns/1ps
// Frame sequencer in front of the filter: latches the per-frame configuration,
// forwards pixels and realigns the filter result with line/frame markers.
module filter_frame_ctrl #(
  parameter int LINE_W   = 640,
  parameter int FRAME_H  = 480,
  parameter int PIPE_LAT = 1
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        start,
  input  logic [1:0]  cfg_mode,
  input  logic [7:0]  cfg_beta,
  input  logic [2:0]  cfg_wb_mode,
  input  logic        in_valid,
  input  logic [31:0] in_data,
  output logic        in_ready,
  output logic [31:0] filt_in,
  output logic [1:0]  filterMode,
  output logic [7:0]  brightnessCoeff,
  output logic [2:0]  wb_mode,
  output logic        wb_en,
  input  logic [31:0] filt_result,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic        out_line_end,
  output logic        out_frame_end,
  output logic        busy,
  output logic        done
);

  localparam int CW = (LINE_W  > 1) ? $clog2(LINE_W)  : 1;
  localparam int RW = (FRAME_H > 1) ? $clog2(FRAME_H) : 1;

  typedef enum logic [2:0] {IDLE, LOAD, STREAM, DRAIN, DONE} state_t;

  typedef struct packed {
    logic vld;
    logic le;
    logic fe;
  } tag_t;

  state_t            state_q, state_d;
  logic [CW-1:0]     col_q, col_d;
  logic [RW-1:0]     row_q, row_d;
  logic [1:0]        mode_q;
  logic [7:0]        beta_q;
  logic [2:0]        wbm_q;
  logic [31:0]       filt_in_q;
  tag_t [PIPE_LAT:0] tag_pipe;
  tag_t              tag_new, tag_tail;
  logic              accept, last_col, last_row;

  assign accept   = in_valid && (state_q == STREAM);
  assign last_col = (col_q == CW'(LINE_W - 1));
  assign last_row = (row_q == RW'(FRAME_H - 1));

  assign tag_new  = '{vld: accept, le: accept && last_col, fe: accept && last_col && last_row};
  assign tag_tail = tag_pipe[PIPE_LAT];

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    row_d    = row_q;
    in_ready = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    wb_en    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = LOAD;
      LOAD: begin
        busy    = 1'b1;
        wb_en   = (cfg_mode == 2'b10);
        col_d   = '0;
        row_d   = '0;
        state_d = STREAM;
      end
      STREAM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (accept) begin
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              row_d   = '0;
              state_d = DRAIN;
            end else begin
              row_d = row_q + RW'(1);
            end
          end else begin
            col_d = col_q + CW'(1);
          end
        end
      end
      DRAIN: begin
        busy = 1'b1;
        // Leave only once the frame-end tag has surfaced at the filter output.
        if (tag_tail.fe) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= 2'b11;
      beta_q    <= '0;
      wbm_q     <= '0;
      filt_in_q <= '0;
      tag_pipe  <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      row_q   <= row_d;
      if (state_q == LOAD) begin
        mode_q <= cfg_mode;
        beta_q <= cfg_beta;
        wbm_q  <= cfg_wb_mode;
      end
      if (accept) filt_in_q <= in_data;
      // Stage 0 sits beside filt_in; the remaining stages track the filter latency.
      tag_pipe[0] <= tag_new;
      for (int i = 1; i <= PIPE_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign filt_in         = filt_in_q;
  assign filterMode      = mode_q;
  assign brightnessCoeff = beta_q;
  assign wb_mode         = wbm_q;
  assign out_valid       = tag_tail.vld;
  assign out_line_end    = tag_tail.le;
  assign out_frame_end   = tag_tail.fe;
  assign out_data        = tag_tail.vld ? filt_result : '0;

endmodule

// File: tb/tb_filter_frame_ctrl.sv
`timescale 1ns/1ps
// Directed bench: a 4x2 frame controller with a one-stage filter model (dut A)
// and a zero-latency filter model (dut B).
module tb_filter_frame_ctrl;

  localparam logic [31:0] K = 32'hA5A5_0F0F;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_beta = '0;
  logic [2:0]  cfg_wb_mode = '0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;

  logic        a_rdy, a_wben, a_ov, a_le, a_fe, a_busy, a_done;
  logic [31:0] a_fin, a_res, a_od;
  logic [1:0]  a_mode;
  logic [7:0]  a_beta;
  logic [2:0]  a_wbm;
  logic        b_rdy, b_wben, b_ov, b_le, b_fe, b_busy, b_done;
  logic [31:0] b_fin, b_res, b_od;
  logic [1:0]  b_mode;
  logic [7:0]  b_beta;
  logic [2:0]  b_wbm;

  logic        sel_b = 1'b0;
  logic        o_rdy, o_wben, o_ov, o_le, o_fe, o_busy, o_done;
  logic [31:0] o_fin, o_od;
  logic [1:0]  o_mode;
  logic [7:0]  o_beta;
  logic [2:0]  o_wbm;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  filter_frame_ctrl #(.LINE_W(4), .FRAME_H(2), .PIPE_LAT(1)) u_a (
    .clk(clk), .n_rst(n_rst), .start(start_a), .cfg_mode(cfg_mode), .cfg_beta(cfg_beta),
    .cfg_wb_mode(cfg_wb_mode), .in_valid(in_valid), .in_data(in_data), .in_ready(a_rdy),
    .filt_in(a_fin), .filterMode(a_mode), .brightnessCoeff(a_beta), .wb_mode(a_wbm),
    .wb_en(a_wben), .filt_result(a_res), .out_valid(a_ov), .out_data(a_od),
    .out_line_end(a_le), .out_frame_end(a_fe), .busy(a_busy), .done(a_done));

  filter_frame_ctrl #(.LINE_W(4), .FRAME_H(2), .PIPE_LAT(0)) u_b (
    .clk(clk), .n_rst(n_rst), .start(start_b), .cfg_mode(cfg_mode), .cfg_beta(cfg_beta),
    .cfg_wb_mode(cfg_wb_mode), .in_valid(in_valid), .in_data(in_data), .in_ready(b_rdy),
    .filt_in(b_fin), .filterMode(b_mode), .brightnessCoeff(b_beta), .wb_mode(b_wbm),
    .wb_en(b_wben), .filt_result(b_res), .out_valid(b_ov), .out_data(b_od),
    .out_line_end(b_le), .out_frame_end(b_fe), .busy(b_busy), .done(b_done));

  // Filter models: one registered stage for A, pure combinational for B.
  always @(posedge clk) a_res <= a_fin ^ K;
  assign b_res = b_fin ^ K;

  always_comb begin
    o_rdy  = sel_b ? b_rdy  : a_rdy;
    o_wben = sel_b ? b_wben : a_wben;
    o_ov   = sel_b ? b_ov   : a_ov;
    o_le   = sel_b ? b_le   : a_le;
    o_fe   = sel_b ? b_fe   : a_fe;
    o_busy = sel_b ? b_busy : a_busy;
    o_done = sel_b ? b_done : a_done;
    o_fin  = sel_b ? b_fin  : a_fin;
    o_od   = sel_b ? b_od   : a_od;
    o_mode = sel_b ? b_mode : a_mode;
    o_beta = sel_b ? b_beta : a_beta;
    o_wbm  = sel_b ? b_wbm  : a_wbm;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s at %0t: observed %h expected %h", tag, $time, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic [1:0] m, input logic [7:0] bt, input logic [2:0] wm);
    cfg_mode = m; cfg_beta = bt; cfg_wb_mode = wm;
    if (sel_b) start_b = 1'b1; else start_a = 1'b1;
    #1;
    chk("idle_busy", 32'(o_busy), 32'd0);
    chk("idle_ready", 32'(o_rdy), 32'd0);
    next_cycle();
    start_a = 1'b0; start_b = 1'b0;
    #1;
    chk("load_busy", 32'(o_busy), 32'd1);
    chk("load_ready", 32'(o_rdy), 32'd0);
    chk("load_wb_en", 32'(o_wben), 32'(m == 2'b10));
    next_cycle();
    chk("cfg_mode", 32'(o_mode), 32'(m));
    chk("cfg_beta", 32'(o_beta), 32'(bt));
    chk("cfg_wbm", 32'(o_wbm), 32'(wm));
  endtask

  // Streams 8 beats with a repeating 4-bit valid pattern and checks every cycle
  // until the done pulse; cfg inputs are scrambled to prove they are ignored.
  task automatic stream(input logic [3:0] pat, input int start_at, input bit hold_iv,
                        input logic [31:0] base, input logic [1:0] xm,
                        input logic [7:0] xb, input logic [2:0] xw);
    int lat;
    int nacc;
    int done_cyc;
    bit fin;
    bit ev [72];
    bit ele[72];
    bit efe[72];
    logic [31:0] ed[72];
    lat = sel_b ? 1 : 2;
    nacc = 0; done_cyc = -1; fin = 1'b0;
    for (int i = 0; i < 72; i++) begin ev[i] = 0; ele[i] = 0; efe[i] = 0; ed[i] = '0; end
    cfg_mode = ~xm; cfg_beta = ~xb; cfg_wb_mode = 3'b010;
    for (int c = 0; c < 64; c++) begin
      bit drv;
      drv = (nacc < 8) ? pat[c % 4] : hold_iv;
      in_valid = drv;
      in_data  = drv ? base + 32'(nacc) : 32'hDEAD_0000 | 32'(c);
      if (c == start_at) begin
        if (sel_b) start_b = 1'b1; else start_a = 1'b1;
      end else begin
        start_a = 1'b0; start_b = 1'b0;
      end
      #1;
      chk("in_ready", 32'(o_rdy), 32'(nacc < 8));
      chk("busy", 32'(o_busy), 32'(c != done_cyc));
      chk("done", 32'(o_done), 32'(c == done_cyc));
      chk("wb_en", 32'(o_wben), 32'd0);
      chk("out_valid", 32'(o_ov), 32'(ev[c]));
      chk("out_data", o_od, ed[c]);
      chk("line_end", 32'(o_le), 32'(ele[c]));
      chk("frame_end", 32'(o_fe), 32'(efe[c]));
      if (nacc < 8 && drv) begin
        ev[c+lat]  = 1;
        ed[c+lat]  = (base + 32'(nacc)) ^ K;
        ele[c+lat] = (nacc % 4 == 3);
        efe[c+lat] = (nacc == 7);
        if (nacc == 7) done_cyc = c + lat + 1;
        nacc++;
      end
      next_cycle();
      if (c == done_cyc) begin
        fin = 1'b1;
        break;
      end
    end
    in_valid = 1'b0; start_a = 1'b0; start_b = 1'b0;
    #1;
    chk("frame_completed", 32'(fin), 32'd1);
    chk("post_busy", 32'(o_busy), 32'd0);
    chk("post_done", 32'(o_done), 32'd0);
    chk("post_ready", 32'(o_rdy), 32'd0);
    chk("post_valid", 32'(o_ov), 32'd0);
    chk("hold_mode", 32'(o_mode), 32'(xm));
    chk("hold_beta", 32'(o_beta), 32'(xb));
    chk("hold_wbm", 32'(o_wbm), 32'(xw));
  endtask

  initial begin
    // Reset values while reset is held
    #12;
    chk("rst_mode", 32'(a_mode), 32'd3);
    chk("rst_beta", 32'(a_beta), 32'd0);
    chk("rst_wbm", 32'(a_wbm), 32'd0);
    chk("rst_fin", a_fin, 32'd0);
    chk("rst_valid", 32'(a_ov), 32'd0);
    chk("rst_data", a_od, 32'd0);
    chk("rst_busy", 32'(a_busy), 32'd0);
    chk("rst_done", 32'(a_done), 32'd0);
    chk("rst_b_mode", 32'(b_mode), 32'd3);
    next_cycle();
    n_rst = 1'b1;
    next_cycle();

    // Back-to-back frame, mode 01, beta 0x20
    start_frame(2'b01, 8'h20, 3'b000);
    stream(4'b1111, -1, 1'b0, 32'h1, 2'b01, 8'h20, 3'b000);

    // White-balance load strobe; wb_mode must survive a mid-frame cfg change
    start_frame(2'b10, 8'h55, 3'b101);
    stream(4'b1111, -1, 1'b0, 32'h10, 2'b10, 8'h55, 3'b101);

    // Gapped input 1,0,0,1
    start_frame(2'b00, 8'h07, 3'b001);
    stream(4'b1001, -1, 1'b0, 32'h100, 2'b00, 8'h07, 3'b001);

    // Stray start mid-stream and in_valid held through drain
    start_frame(2'b01, 8'h99, 3'b110);
    stream(4'b1111, 3, 1'b1, 32'h200, 2'b01, 8'h99, 3'b110);
    start_frame(2'b01, 8'h9A, 3'b110);
    stream(4'b1111, -1, 1'b0, 32'h300, 2'b01, 8'h9A, 3'b110);

    // Reset after 5 accepted beats aborts the frame
    start_frame(2'b10, 8'h33, 3'b111);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h400 + 32'(i);
      next_cycle();
    end
    in_valid = 1'b0;
    n_rst = 1'b0;
    #1;
    chk("abort_mode", 32'(a_mode), 32'd3);
    chk("abort_beta", 32'(a_beta), 32'd0);
    chk("abort_wbm", 32'(a_wbm), 32'd0);
    chk("abort_fin", a_fin, 32'd0);
    chk("abort_valid", 32'(a_ov), 32'd0);
    chk("abort_data", a_od, 32'd0);
    chk("abort_busy", 32'(a_busy), 32'd0);
    chk("abort_ready", 32'(a_rdy), 32'd0);
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      chk("abort_no_done", 32'(a_done), 32'd0);
      chk("abort_no_valid", 32'(a_ov), 32'd0);
    end
    n_rst = 1'b1;
    next_cycle();
    chk("abort_idle_busy", 32'(a_busy), 32'd0);
    chk("abort_idle_done", 32'(a_done), 32'd0);
    start_frame(2'b01, 8'h44, 3'b010);
    stream(4'b1111, -1, 1'b0, 32'h500, 2'b01, 8'h44, 3'b010);

    // Zero-latency filter build
    sel_b = 1'b1;
    #1;
    start_frame(2'b00, 8'h44, 3'b011);
    stream(4'b1111, -1, 1'b0, 32'h600, 2'b00, 8'h44, 3'b011);
    start_frame(2'b11, 8'h01, 3'b100);
    stream(4'b1001, -1, 1'b1, 32'h700, 2'b11, 8'h01, 3'b100);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/filter_frame_ctrl.md
Name: filter_frame_ctrl

Overview:
- Frame-level sequencer in front of the filter top level.
- Accepts a start command and a pixel stream with a valid/ready handshake.
- Latches the filter configuration once per frame so filterMode, brightnessCoeff, wb_mode and wb_en stay stable for the whole frame.
- Forwards pixels to the filter and realigns the filter result with line/frame markers, compensating the filter's pipeline latency, then reports frame completion.

Parameters:
- LINE_W, 640, pixels per line (≥2).
- FRAME_H, 480, lines per frame (≥1).
- PIPE_LAT, 1, clock cycles from filter input to filter result (≥0; 1 covers the registered horizontal blur path).

Ports:
- clk  in  1  system clock, rising edge.
- n_rst  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin a frame.
- cfg_mode  in  2  requested filter mode.
- cfg_beta  in  8  requested brightness coefficient.
- cfg_wb_mode  in  3  requested white-balance mode.
- in_valid  in  1  input pixel valid.
- in_data  in  32  raw input pixel word.
- in_ready  out  1  controller accepts a pixel this cycle.
- filt_in  out  32  pixel word driven to the filter input.
- filterMode  out  2  latched mode to the filter.
- brightnessCoeff  out  8  latched beta to the filter.
- wb_mode  out  3  latched white-balance mode to the filter.
- wb_en  out  1  white-balance load strobe to the filter.
- filt_result  in  32  filter result.
- out_valid  out  1  out_data valid.
- out_data  out  32  filter result aligned to out_valid.
- out_line_end  out  1  marks the last pixel of a line.
- out_frame_end  out  1  marks the last pixel of the frame.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse when the frame is fully drained.

Behaviour:
- Reset values (all asynchronous): state IDLE; counters 0; filterMode 2'b11; brightnessCoeff 0; wb_mode 0; wb_en 0; filt_in 0; out_valid/out_line_end/out_frame_end 0; out_data 0; busy 0; done 0; delay line cleared.
- FSM states: IDLE, LOAD, STREAM, DRAIN, DONE.
- IDLE:
  - in_ready=0, busy=0.
  - start=1 → LOAD.
- LOAD (exactly one cycle):
  - Register cfg_mode, cfg_beta, cfg_wb_mode into filterMode, brightnessCoeff, wb_mode.
  - wb_en=1 for this cycle only, and only when cfg_mode==2'b10; otherwise 0.
  - busy=1. Next state STREAM.
- STREAM:
  - in_ready=1, busy=1.
  - A beat is accepted when in_valid & in_ready.
  - On acceptance, filt_in <= in_data (registered, one cycle).
  - On acceptance, col increments; at col==LINE_W-1, col wraps to 0 and row increments.
  - No acceptance → counters and filt_in hold; in_valid gaps are legal.
  - Accepting the pixel at col==LINE_W-1 and row==FRAME_H-1 → DRAIN, with in_ready=0 from the next cycle.
- Tag pipeline:
  - Each accepted beat launches a tag {valid, line_end, frame_end} into a delay line of depth 1+PIPE_LAT.
  - The 1 is the filt_in register; total latency from acceptance to out_valid is 1+PIPE_LAT cycles.
  - At the tail: out_valid/out_line_end/out_frame_end = tag bits; out_data = filt_result when valid, else 0.
  - No downstream backpressure; consumers must accept every out_valid beat.
- DRAIN:
  - in_ready=0, busy=1.
  - Remains until the tag with frame_end leaves the delay line (out_frame_end asserted), then → DONE.
- DONE:
  - done=1 for one cycle, busy=0, → IDLE.
  - Configuration outputs keep their values until the next LOAD.
- Boundary rules:
  - start outside IDLE is ignored.
  - cfg_* changes outside LOAD have no effect on the outputs.
  - in_valid outside STREAM is never accepted.
  - Frame pixel count is exactly LINE_W*FRAME_H.
  - Counter widths are $clog2 of LINE_W and FRAME_H (minimum 1 bit).
  - Reset asserted mid-frame aborts immediately: all tags are dropped and no done pulse is produced.
  - start in the same cycle as done: done cycle is in state DONE, so start is ignored; a new start is honoured from IDLE onward.

Test Plan:
- LINE_W=4, FRAME_H=2, PIPE_LAT=1; cfg_mode=2'b01, cfg_beta=8'h20; start, then 8 back-to-back beats 0x00000001..0x00000008 → filterMode=01 and brightnessCoeff=0x20 from the cycle after LOAD; wb_en never asserts; out_valid exactly 8 cycles, first 2 cycles after the first accept; out_line_end on beats 4 and 8; out_frame_end on beat 8; done one cycle after the last out_valid.
- cfg_mode=2'b10, cfg_wb_mode=3'b101 → wb_en high exactly one cycle (LOAD) and wb_mode=101; changing cfg_wb_mode mid-frame to 3'b010 leaves wb_mode=101.
- in_valid toggled 1,0,0,1 pattern → counters advance only on accepted beats; out_valid pattern mirrors the accept pattern delayed by 2 cycles; 8 pixels total still raise out_frame_end once.
- start pulsed during STREAM and in_valid held high during DRAIN → no restart and no extra accepts; in_ready=0 in DRAIN; after done, a new start begins a fresh frame with col=row=0.
- n_rst asserted after 5 accepted beats → all outputs return to reset values asynchronously (filterMode=11); no done pulse; after release, a full frame completes normally.
- PIPE_LAT=0 build → out_valid 1 cycle after acceptance; out_frame_end coincides with the cycle before done.
